// File: rtl/sevenseg_scan.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with frame snapshot,
// anti-ghost blanking gap, minutes leading-zero blanking and paused-blink mode.
module sevenseg_scan #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLANK_CYC   = 50,
   parameter int unsigned BLINK_DIV   = 25000000,
   parameter bit          LZ_BLANK    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digit_min,
   input  logic [3:0] digit_st,
   input  logic [3:0] digit_su,
   input  logic [3:0] digit_tenths,
   input  logic       running,
   input  logic       dir,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);
   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_V   = CW'(BLANK_CYC);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          phase;
   logic [15:0]   snapshot;   // {min, st, su, tenths}

   logic [3:0] digit;
   logic [6:0] seg_d;
   logic [3:0] an_d;
   logic       dp_d;
   logic       blink_en;

   always_comb begin
      digit    = '0;
      seg_d    = '1;
      an_d     = '1;
      dp_d     = 1'b1;
      blink_en = !running && (snapshot != 16'h0000);

      case (idx)
         2'd0:    digit = snapshot[3:0];
         2'd1:    digit = snapshot[7:4];
         2'd2:    digit = snapshot[11:8];
         default: digit = snapshot[15:12];
      endcase

      case (digit)
         4'd0:    seg_d = 7'b1000000;
         4'd1:    seg_d = 7'b1111001;
         4'd2:    seg_d = 7'b0100100;
         4'd3:    seg_d = 7'b0110000;
         4'd4:    seg_d = 7'b0011001;
         4'd5:    seg_d = 7'b0010010;
         4'd6:    seg_d = 7'b0000010;
         4'd7:    seg_d = 7'b1111000;
         4'd8:    seg_d = 7'b0000000;
         4'd9:    seg_d = 7'b0010000;
         default: seg_d = 7'b0111111;
      endcase

      if (LZ_BLANK && (idx == 2'd3) && (digit == 4'd0))
         seg_d = '1;

      if ((idx == 2'd1) || ((idx == 2'd3) && dir))
         dp_d = 1'b0;

      // Blank gap and blink both only ever force anodes off, never on.
      if ((cnt < BLANK_V) || (blink_en && phase))
         an_d = '1;
      else
         an_d = ~(4'b0001 << idx);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         idx       <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
         snapshot  <= '0;
         an        <= '1;
         seg       <= '1;
         dp        <= 1'b1;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
            if (idx == 2'd3)
               snapshot <= {digit_min, digit_st, digit_su, digit_tenths};
         end else begin
            cnt <= cnt + CW'(1);
         end

         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end

         an  <= an_d;
         seg <= seg_d;
         dp  <= dp_d;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: directed and random steps checked every cycle against
// a time-based model (slot, digit and blink phase derived from elapsed cycles).
module tb_sevenseg_scan;

   localparam int R  = 4;
   localparam int BK = 1;
   localparam int BL = 64;

   logic       clk;
   logic       rst;
   logic [3:0] digit_min, digit_st, digit_su, digit_tenths;
   logic       running, dir;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int          tests = 0;
   int          fails = 0;
   int          k;
   logic [15:0] msnap;
   logic [6:0]  seg_tab [16];
   logic [3:0]  an_tab  [4];

   sevenseg_scan #(
      .REFRESH_DIV(R),
      .BLANK_CYC(BK),
      .BLINK_DIV(BL),
      .LZ_BLANK(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .digit_min(digit_min),
      .digit_st(digit_st),
      .digit_su(digit_su),
      .digit_tenths(digit_tenths),
      .running(running),
      .dir(dir),
      .an(an),
      .seg(seg),
      .dp(dp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s at k=%0d: got %b expected %b", tag, k, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_an"},  {3'b0, an},  7'b0001111);
      chk({tag, "_seg"}, seg,         7'b1111111);
      chk({tag, "_dp"},  {6'b0, dp},  7'b0000001);
   endtask

   // One clock edge: predict from elapsed cycle count, advance, then compare.
   task automatic tick();
      int         pos, slot, ph;
      logic [3:0] d;
      logic [3:0] ea;
      logic [6:0] es;
      logic       ed;
      pos  = k % R;
      slot = (k / R) % 4;
      ph   = (k / BL) % 2;
      d    = msnap[slot*4 +: 4];
      es   = seg_tab[d];
      if (slot == 3 && d == 4'd0) es = 7'b1111111;
      ed   = (slot == 1 || (slot == 3 && dir)) ? 1'b0 : 1'b1;
      if (pos < BK || (!running && msnap != 16'h0 && ph == 1))
         ea = 4'b1111;
      else
         ea = an_tab[slot];
      if (pos == R - 1 && slot == 3)
         msnap = {digit_min, digit_st, digit_su, digit_tenths};
      @(posedge clk);
      k++;
      #1;
      chk("an",  {3'b0, an}, {3'b0, ea});
      chk("seg", seg, es);
      chk("dp",  {6'b0, dp}, {6'b0, ed});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_digits(input logic [15:0] v);
      {digit_min, digit_st, digit_su, digit_tenths} = v;
   endtask

   initial begin
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                  7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
      an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      rst = 1'b0;
      running = 1'b0;
      dir = 1'b0;
      set_digits(16'h0000);
      k = 0;
      msnap = 16'h0;

      #12;
      chk_reset("rst_init");
      @(negedge clk);
      rst = 1'b1;

      // First frame shows the zero snapshot, then 1234.
      running = 1'b1;
      set_digits(16'h1234);
      run(40);

      // Change digits mid-frame in slot 1; the frame in progress keeps 1234.
      for (int i = 0; i < 16 && !(((k / R) % 4) == 1 && (k % R) == 2); i++) tick();
      set_digits(16'h5678);
      run(24);

      // Dash, leading-zero blank and count-down dp.
      set_digits(16'h02C9);
      dir = 1'b1;
      run(32);
      dir = 1'b0;

      // Paused blink with nonzero value, then all-zero value (no blink).
      running = 1'b0;
      set_digits(16'h0005);
      run(300);
      set_digits(16'h0000);
      run(200);

      // Resume running during a blink-off window.
      set_digits(16'h0005);
      for (int i = 0; i < 400 && !(msnap != 16'h0 && ((k / BL) % 2) == 1 && (k % BL) > 8); i++) tick();
      running = 1'b1;
      run(12);

      // Asynchronous reset mid-slot, held across an edge, then released.
      dir = 1'b1;
      run(2);
      #2 rst = 1'b0;
      #1 chk_reset("rst_async");
      @(posedge clk);
      #1 chk_reset("rst_held");
      @(negedge clk);
      rst = 1'b1;
      k = 0;
      msnap = 16'h0;
      run(24);

      // Randomized digits and control.
      for (int it = 0; it < 60; it++) begin
         set_digits(16'($urandom));
         if ($urandom_range(3, 0) == 0) set_digits(16'($urandom_range(15, 0)));
         running = ($urandom_range(2, 0) != 0);
         dir     = 1'($urandom);
         run($urandom_range(24, 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
